video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Source-side video timing generator that produces the pixel stream the MiST video pipeline consumes.
- Derives a pixel clock enable from clk_sys at the same 4x/2x ratios the pipeline assumes, and runs horizontal/vertical counters.
- Exposes the raster position as a pixel request to the core, and returns registered, blanked RGB with active-low HSync/VSync.
- Sits between core pixel logic and the video pipeline input (R/G/B/HSync/VSync).

Parameters:
COLOR_DEPTH, 6, bits per colour channel (1-6)
HCNT_WIDTH, 10, width of hcnt
VCNT_WIDTH, 10, width of vcnt
H_ACTIVE, 320, visible pixels per line
H_FP, 8, horizontal front porch (pixels)
H_SYNC, 32, hsync width (pixels)
H_BP, 40, horizontal back porch (pixels)
V_ACTIVE, 240, visible lines
V_FP, 3, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 16, vertical back porch (lines)

Ports:
clk_sys  in  1  master clock (4x or 2x pixel rate)
reset_n  in  1  asynchronous active-low reset
ce_divider  in  1  0: ce_pix = clk_sys/4; 1: ce_pix = clk_sys/2
R_in  in  COLOR_DEPTH  core red for requested position
G_in  in  COLOR_DEPTH  core green
B_in  in  COLOR_DEPTH  core blue
ce_pix  out  1  pixel clock enable, one clk_sys cycle wide
hcnt  out  HCNT_WIDTH  requested pixel column
vcnt  out  VCNT_WIDTH  requested line
new_frame  out  1  one-cycle pulse at frame start
R  out  COLOR_DEPTH  registered red, 0 in blanking
G  out  COLOR_DEPTH  registered green
B  out  COLOR_DEPTH  registered blue
HSync  out  1  active-low horizontal sync
VSync  out  1  active-low vertical sync
HBlank  out  1  high outside active columns
VBlank  out  1  high outside active lines

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 400; V_TOTAL = 262.
- Legality: H_TOTAL < 2^HCNT_WIDTH and V_TOTAL < 2^VCNT_WIDTH; every porch/sync >= 1. Illegal values are a static elaboration error.
- Reset (async, any time, including mid-frame):
  - div=0, hcnt=0, vcnt=0.
  - ce_pix=0, new_frame=0.
  - R=G=B=0, HSync=VSync=1, HBlank=VBlank=1.
  - First edge after reset_n rises: div increments from 0.
- Divider:
  - 2-bit div increments every clk_sys and wraps at 3.
  - ce_pix is registered: asserts when next div == 3 (ce_divider=0) or next div[0] == 1 (ce_divider=1).
  - ce_divider changes take effect on the next clk_sys; div is never reset by the change. No glitch, no double pulse.
- Counters (on ce_pix only):
  - hcnt = H_TOTAL-1 wraps to 0 and advances vcnt.
  - vcnt = V_TOTAL-1 wraps to 0 at the hcnt wrap.
  - Both counters hold between ce_pix pulses.
- Output stage (on the same ce_pix, using pre-increment hcnt/vcnt):
  - HBlank <= (hcnt >= H_ACTIVE); VBlank <= (vcnt >= V_ACTIVE).
  - HSync <= ~(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)).
  - VSync <= ~(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)). VSync therefore changes only at the first pixel of a line.
  - RGB <= active ? {R,G,B}_in : 0, where active = ~HBlank_next & ~VBlank_next.
- Latency and handshake:
  - Outputs for position (h,v) appear one ce_pix period after hcnt/vcnt present (h,v).
  - The core must hold R_in/G_in/B_in valid by the next ce_pix edge. There is no back-pressure.
- new_frame: high for exactly one clk_sys cycle, coincident with the ce_pix on which (hcnt,vcnt) = (0,0) is consumed.
- All outputs are registered; none are combinational from inputs.

Decomposition:
- Shared package video_pkg holds:
  - the default timing constants (320x240 @ H_TOTAL 400, V_TOTAL 262);
  - the H_TOTAL/V_TOTAL derivation functions;
  - a sync-window compare function reused by the sync and blank logic.
- One natural sub-module, video_ce_gen: the divider and ce_pix generation, reusable by other cores.
- Counter and output-stage logic stay in video_timing_gen.

Test Plan:
- Reset release, ce_divider=0: first ce_pix on clk_sys edge 3. Spacing is 4 cycles; HSync=VSync=1 and RGB=0 until the first qualifying ce_pix.
- Line timing, R_in=6'h3F always: HBlank rises after 320 ce_pix. HSync is low for exactly 32 ce_pix, starting 328 pixels after line start; line period is 400 ce_pix = 1600 clk_sys.
- Frame timing: VBlank high for 22 lines. VSync low for lines 243-245 (3 lines), edges aligned to the hcnt=0 output. new_frame period is 262*400*4 = 419200 clk_sys.
- Echo check, R_in=hcnt[5:0], G_in=vcnt[5:0]: output pixel n of line m equals {n[5:0], m[5:0]}, one ce_pix late. RGB=0 at hcnt 320-399.
- Switch ce_divider 0->1 mid-line: ce_pix spacing becomes 2 with no missing or duplicate pulse; hcnt is continuous.
- Assert reset_n low at hcnt=150, vcnt=100: all outputs reach reset values without a clock edge. After release, the frame restarts from (0,0) and new_frame pulses on the first ce_pix.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared constants and helpers for the video timing generator.
//   - Default 320x240 raster timing (H_TOTAL 400, V_TOTAL 262).
//   - total_len(): line/frame length from active + porches + sync.
//   - in_window(): half-open [lo, hi) position compare, shared by the
//     sync and blanking decode.
package video_pkg;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 40;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 16;

  function automatic int total_len(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = total_len(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = total_len(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  function automatic logic in_window(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/video_ce_gen.sv
// video_ce_gen: pixel clock-enable generator.
//   clk_sys    in  master clock (4x or 2x pixel rate)
//   reset_n    in  asynchronous active-low reset
//   ce_divider in  0: ce_pix every 4th clk_sys, 1: every 2nd clk_sys
//   ce_pix     out registered one-cycle pixel enable
//   ce_next    out value ce_pix takes at the next clk_sys edge, so that
//                  companion registers can pulse in step with ce_pix
module video_ce_gen (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce_divider,
  output logic ce_pix,
  output logic ce_next
);

  logic [1:0] div;
  logic [1:0] div_next;

  // The divider free-runs through a rate change; div == 3 always has an odd
  // value, so switching modes can neither drop nor double a pulse.
  always_comb begin
    div_next = div + 2'd1;
    ce_next  = ce_divider ? div_next[0] : (div_next == 2'd3);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div    <= 2'd0;
      ce_pix <= 1'b0;
    end else begin
      div    <= div_next;
      ce_pix <= ce_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: source-side raster timing generator.
//   clk_sys, reset_n     master clock, asynchronous active-low reset
//   ce_divider           pixel rate select (0: clk_sys/4, 1: clk_sys/2)
//   R_in, G_in, B_in     core colour for the position on hcnt/vcnt
//   ce_pix               pixel clock enable
//   hcnt, vcnt           raster position requested from the core
//   new_frame            one-cycle pulse with the ce_pix consuming (0,0)
//   R, G, B              registered colour, zero while blanked
//   HSync, VSync         active-low syncs
//   HBlank, VBlank       high outside the active area
// Outputs for position (h,v) appear one ce_pix period after hcnt/vcnt
// present (h,v); the core has until the next ce_pix to supply the colour.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int COLOR_DEPTH = 6,
  parameter int HCNT_WIDTH  = 10,
  parameter int VCNT_WIDTH  = 10,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce_divider,
  input  logic [COLOR_DEPTH-1:0] R_in,
  input  logic [COLOR_DEPTH-1:0] G_in,
  input  logic [COLOR_DEPTH-1:0] B_in,
  output logic                   ce_pix,
  output logic [HCNT_WIDTH-1:0]  hcnt,
  output logic [VCNT_WIDTH-1:0]  vcnt,
  output logic                   new_frame,
  output logic [COLOR_DEPTH-1:0] R,
  output logic [COLOR_DEPTH-1:0] G,
  output logic [COLOR_DEPTH-1:0] B,
  output logic                   HSync,
  output logic                   VSync,
  output logic                   HBlank,
  output logic                   VBlank
);

  localparam int H_TOTAL  = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (COLOR_DEPTH < 1 || COLOR_DEPTH > 6) begin : g_bad_depth
    $error("video_timing_gen: COLOR_DEPTH must be 1..6");
  end
  if (H_TOTAL >= (1 << HCNT_WIDTH) || V_TOTAL >= (1 << VCNT_WIDTH)) begin : g_bad_width
    $error("video_timing_gen: counter width too small for raster total");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("video_timing_gen: every timing interval must be at least 1");
  end

  logic ce_next;
  logic h_last, v_last, frame_start;
  logic hblank_next, vblank_next, hsync_next, vsync_next, active;

  video_ce_gen u_ce_gen (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce_divider (ce_divider),
    .ce_pix     (ce_pix),
    .ce_next    (ce_next)
  );

  // Decode from the position currently presented (pre-increment).
  always_comb begin
    h_last      = (hcnt == HCNT_WIDTH'(H_TOTAL - 1));
    v_last      = (vcnt == VCNT_WIDTH'(V_TOTAL - 1));
    frame_start = (hcnt == '0) && (vcnt == '0);
    hblank_next = in_window(int'(hcnt), H_ACTIVE, H_TOTAL);
    vblank_next = in_window(int'(vcnt), V_ACTIVE, V_TOTAL);
    hsync_next  = ~in_window(int'(hcnt), HS_START, HS_END);
    vsync_next  = ~in_window(int'(vcnt), VS_START, VS_END);
    active      = ~hblank_next & ~vblank_next;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce_pix) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // new_frame is registered from ce_next so it lands in the same cycle as
  // ce_pix; hcnt/vcnt cannot move on that edge because ce_pix is never high
  // two cycles running.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      new_frame <= 1'b0;
      R         <= '0;
      G         <= '0;
      B         <= '0;
      HSync     <= 1'b1;
      VSync     <= 1'b1;
      HBlank    <= 1'b1;
      VBlank    <= 1'b1;
    end else begin
      new_frame <= ce_next & frame_start;
      if (ce_pix) begin
        HBlank <= hblank_next;
        VBlank <= vblank_next;
        HSync  <= hsync_next;
        VSync  <= vsync_next;
        R      <= active ? R_in : '0;
        G      <= active ? G_in : '0;
        B      <= active ? B_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. A default-timing instance checks one full
// 400-pixel line; a reduced-raster instance (36x17 total, 20x10 active)
// is run through whole frames, a rate switch and a mid-frame reset.
module tb_video_timing_gen;

  // Reduced raster: H 20 active + 4 fp + 6 sync + 6 bp = 36,
  // V 10 active + 2 fp + 3 sync + 2 bp = 17, frame = 612 pixels.
  localparam int SH_A = 20, SH_FP = 4, SH_S = 6, SH_BP = 6, SH_T = 36;
  localparam int SV_A = 10, SV_FP = 2, SV_S = 3, SV_BP = 2, SV_T = 17;
  localparam int S_FRAME = 612;
  localparam int HS_LO = 24, HS_HI = 30;   // hsync pixels 24..29
  localparam int VS_LO = 12, VS_HI = 15;   // vsync lines 12..14

  logic clk = 1'b0;
  logic reset_n;
  logic div_s, div_d;

  logic [5:0] r_s_in, g_s_in, b_s_in, r_s, g_s, b_s;
  logic [9:0] hcnt_s, vcnt_s;
  logic ce_s, nf_s, hs_s, vs_s, hb_s, vb_s;

  logic [5:0] r_d_in, g_d_in, b_d_in, r_d, g_d, b_d;
  logic [9:0] hcnt_d, vcnt_d;
  logic ce_d, nf_d, hs_d, vs_d, hb_d, vb_d;

  // Core model: echo the requested position as colour.
  assign r_s_in = hcnt_s[5:0];
  assign g_s_in = vcnt_s[5:0];
  assign b_s_in = 6'h2A;
  assign r_d_in = 6'h3F;
  assign g_d_in = 6'h00;
  assign b_d_in = 6'h00;

  video_timing_gen #(
    .COLOR_DEPTH(6), .HCNT_WIDTH(10), .VCNT_WIDTH(10),
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_divider(div_s),
    .R_in(r_s_in), .G_in(g_s_in), .B_in(b_s_in),
    .ce_pix(ce_s), .hcnt(hcnt_s), .vcnt(vcnt_s), .new_frame(nf_s),
    .R(r_s), .G(g_s), .B(b_s),
    .HSync(hs_s), .VSync(vs_s), .HBlank(hb_s), .VBlank(vb_s)
  );

  video_timing_gen dut_def (
    .clk_sys(clk), .reset_n(reset_n), .ce_divider(div_d),
    .R_in(r_d_in), .G_in(g_d_in), .B_in(b_d_in),
    .ce_pix(ce_d), .hcnt(hcnt_d), .vcnt(vcnt_d), .new_frame(nf_d),
    .R(r_d), .G(g_d), .B(b_d),
    .HSync(hs_d), .VSync(vs_d), .HBlank(hb_d), .VBlank(vb_d)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reduced-raster monitor: pixel-by-pixel expectations.
  int s_pix = 0, s_cons = 0, s_last = 0, s_gap, s_h, s_v;
  int s_sw_cyc = 32'h7fffffff;
  int s_nf_t[2];
  int s_nf_n = 0;
  bit s_prev = 1'b0, s_first = 1'b1, s_act;

  always @(negedge clk) begin
    if (!reset_n) begin
      s_prev  = 1'b0;
      s_pix   = 0;
      s_cons  = 0;
      s_first = 1'b1;
    end else begin
      if (s_prev) begin
        s_h   = s_pix % SH_T;
        s_v   = (s_pix / SH_T) % SV_T;
        s_act = (s_h < SH_A) && (s_v < SV_A);
        check_val("hblank", int'(hb_s), int'(s_h >= SH_A));
        check_val("vblank", int'(vb_s), int'(s_v >= SV_A));
        check_val("hsync", int'(hs_s), int'(!(s_h >= HS_LO && s_h < HS_HI)));
        check_val("vsync", int'(vs_s), int'(!(s_v >= VS_LO && s_v < VS_HI)));
        check_val("echo_r", int'(r_s), s_act ? s_h : 0);
        check_val("echo_g", int'(g_s), s_act ? s_v : 0);
        check_val("echo_b", int'(b_s), s_act ? 42 : 0);
        s_pix++;
      end
      if (ce_s) begin
        check_val("hcnt", int'(hcnt_s), s_cons % SH_T);
        check_val("vcnt", int'(vcnt_s), (s_cons / SH_T) % SV_T);
        check_val("new_frame", int'(nf_s), int'(s_cons % S_FRAME == 0));
        if (!s_first) begin
          s_gap = cyc - s_last;
          if (cyc > s_sw_cyc && s_last <= s_sw_cyc)
            check_val("ce_gap_switch", int'(s_gap >= 2 && s_gap <= 4), 1);
          else
            check_val("ce_gap", s_gap, (cyc > s_sw_cyc) ? 2 : 4);
        end
        s_first = 1'b0;
        s_last  = cyc;
        s_cons++;
      end else begin
        check_val("nf_idle", int'(nf_s), 0);
      end
      if (nf_s && s_nf_n < 2) begin
        s_nf_t[s_nf_n] = cyc;
        s_nf_n++;
      end
      s_prev = ce_s;
    end
  end

  // Default-timing monitor: measurements over the first line.
  bit d_on = 1'b0, d_prev = 1'b0;
  int d_pix = 0, d_cons = 0, d_t0 = 0, d_t400 = 0;
  int d_hb_first = -1, d_hs_first = -1, d_hs_low = 0, d_r_bad = 0, d_vb_bad = 0;
  int d_wrap_h = -1, d_wrap_v = -1;

  always @(negedge clk) begin
    if (reset_n && d_on) begin
      if (d_prev) begin
        if (d_pix < 400) begin
          if (hb_d && d_hb_first < 0) d_hb_first = d_pix;
          if (!hs_d) begin
            d_hs_low++;
            if (d_hs_first < 0) d_hs_first = d_pix;
          end
          if (int'(r_d) != ((d_pix < 320) ? 63 : 0)) d_r_bad++;
          if (vb_d) d_vb_bad++;
        end
        d_pix++;
      end
      if (ce_d) begin
        if (d_cons == 0) d_t0 = cyc;
        if (d_cons == 400) begin
          d_t400   = cyc;
          d_wrap_h = int'(hcnt_d);
          d_wrap_v = int'(vcnt_d);
        end
        d_cons++;
      end
      d_prev = ce_d;
    end
  end

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ce"}, int'(ce_s), 0);
    check_val({tag, "_hcnt"}, int'(hcnt_s), 0);
    check_val({tag, "_vcnt"}, int'(vcnt_s), 0);
    check_val({tag, "_nf"}, int'(nf_s), 0);
    check_val({tag, "_rgb"}, int'({r_s, g_s, b_s}), 0);
    check_val({tag, "_hsync"}, int'(hs_s), 1);
    check_val({tag, "_vsync"}, int'(vs_s), 1);
    check_val({tag, "_hblank"}, int'(hb_s), 1);
    check_val({tag, "_vblank"}, int'(vb_s), 1);
    check_val({tag, "_def_hcnt"}, int'(hcnt_d), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    div_s   = 1'b0;
    div_d   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");

    #2 reset_n = 1'b1;
    d_on = 1'b1;

    // Reset release at /4: first ce_pix on edge 3, then every 4.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_val("ce_start", int'(ce_s), int'(k == 3 || k == 7));
      check_val("ce_start_def", int'(ce_d), int'(k == 3 || k == 7));
      if (k == 3) begin
        check_val("nf_first", int'(nf_s), 1);
        check_val("hsync_pre", int'(hs_s), 1);
        check_val("rgb_pre", int'(r_d), 0);
        check_val("hblank_pre", int'(hb_d), 1);
      end
      if (k == 4) begin
        check_val("def_r_px0", int'(r_d), 63);
        check_val("def_hblank_px0", int'(hb_d), 0);
        check_val("def_vblank_px0", int'(vb_d), 0);
      end
    end

    // Default-timing line.
    for (int i = 0; i < 2000 && d_pix <= 400; i++) @(negedge clk);
    check_val("def_line_reached", int'(d_pix > 400), 1);
    check_val("def_hblank_rise", d_hb_first, 320);
    check_val("def_hsync_start", d_hs_first, 328);
    check_val("def_hsync_len", d_hs_low, 32);
    check_val("def_r_errors", d_r_bad, 0);
    check_val("def_vblank_errors", d_vb_bad, 0);
    check_val("def_line_period", d_t400 - d_t0, 1600);
    check_val("def_wrap_hcnt", d_wrap_h, 0);
    check_val("def_wrap_vcnt", d_wrap_v, 1);

    // Switch to /2 mid-line in the second frame.
    for (int i = 0; i < 4000 && s_cons < 662; i++) @(negedge clk);
    check_val("switch_reached", int'(s_cons >= 662), 1);
    div_s    = 1'b1;
    s_sw_cyc = cyc;
    check_val("nf_count", int'(s_nf_n >= 2), 1);
    check_val("nf_period", s_nf_t[1] - s_nf_t[0], 2448);

    // Mid-frame asynchronous reset at hcnt=15, vcnt=5.
    for (int i = 0; i < 3000 && !(hcnt_s == 10'd15 && vcnt_s == 10'd5 && s_cons > 700); i++)
      @(negedge clk);
    check_val("midrst_reached", int'(hcnt_s == 10'd15 && vcnt_s == 10'd5), 1);
    check_val("midrst_pre_r", int'(r_s), 14);
    check_val("midrst_pre_g", int'(g_s), 5);
    #2 reset_n = 1'b0;
    #1 check_reset_state("midrst");

    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val("restart_ce", int'(ce_s), k % 2);
      check_val("restart_nf", int'(nf_s), int'(k == 1));
      check_val("restart_hcnt", int'(hcnt_s), k / 2);
      check_val("restart_vcnt", int'(vcnt_s), 0);
      check_val("restart_hblank", int'(hb_s), int'(k < 2));
    end
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
